// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full adder (two half adders + OR) reused over WIDTH
// cycles, LSB first, behind a start/busy/done handshake.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_shift;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

  half_adder u_ha1 (.x(a_sr[0]), .y(b_sr[0]), .s(ha1_s), .c(ha1_c));
  half_adder u_ha2 (.x(ha1_s),   .y(carry),   .s(ha2_s), .c(ha2_c));
  assign fa_c = ha1_c | ha2_c;

  // New sum bit enters at the MSB so the LSB-first result lands aligned.
  generate
    if (WIDTH == 1) begin : g_sum1
      assign sum_shift = ha2_s;
    end else begin : g_sumn
      assign sum_shift = {ha2_s, sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum   <= sum_shift;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) cout <= fa_c;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: WIDTH=8 and WIDTH=1 instances; stimulus
// pushes expected {cout,sum}, per-instance monitors pop on done.
module tb_serial_add_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

  serial_add_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  int passed = 0, total = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int   run8 = 0, run1 = 0;
  logic pd8 = 1'b0, pd1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  // Monitors: result, single-cycle done, busy length exactly WIDTH.
  always @(negedge clk) begin
    if (done8) begin
      check("done8_pulse", 32'(pd8), 32'd0);
      check("busy8_len", 32'(run8), 32'd8);
      if (q8.size() == 0) fail("done8_unexpected");
      else check("result8", 32'({cout8, sum8}), 32'(q8.pop_front()));
      run8 = 0;
    end else if (busy8) run8++;
    else run8 = 0;
    pd8 = done8;
  end

  always @(negedge clk) begin
    if (done1) begin
      check("done1_pulse", 32'(pd1), 32'd0);
      check("busy1_len", 32'(run1), 32'd1);
      if (q1.size() == 0) fail("done1_unexpected");
      else check("result1", 32'({cout1, sum1}), 32'(q1.pop_front()));
      run1 = 0;
    end else if (busy1) run1++;
    else run1 = 0;
    pd1 = done1;
  end

  task automatic wait_idle8();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy8 && !done8) return;
    end
    fail("idle8_timeout");
  endtask

  task automatic wait_idle1();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy1 && !done1) return;
    end
    fail("idle1_timeout");
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp, input bit push);
    wait_idle8();
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    if (push) q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic go1(input logic a, input logic b, input logic c, input logic [1:0] exp);
    wait_idle1();
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    q1.push_back(exp);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  initial begin
    int   n, last, cyc;
    logic pb;

    repeat (3) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8",  32'(sum8),  32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;

    // Directed vectors with hand-computed {cout,sum}
    go8(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b1);
    go8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    go8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);

    // Start and operand changes during RUN and DONE must be ignored
    wait_idle8();
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    q8.push_back(9'h046);
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) break;
    end
    @(negedge clk);
    check("start_in_done_ignored", 32'(busy8), 32'd0);
    start8 = 1'b0;

    // Reset during the 4th RUN cycle aborts with no done
    go8(8'hF0, 8'h0F, 1'b0, 9'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy8", 32'(busy8), 32'd0);
    check("abort_done8", 32'(done8), 32'd0);
    check("abort_sum8",  32'(sum8),  32'd0);
    check("abort_cout8", 32'(cout8), 32'd0);
    go8(8'h01, 8'h01, 1'b0, 9'h002, 1'b1);

    // Back-to-back with start held: accepted every WIDTH+2 cycles
    wait_idle8();
    n = 0; last = -1; cyc = 0; pb = 1'b0;
    start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int k = 0; k < 12000 && n < 1000; k++) begin
      @(negedge clk);
      cyc++;
      if (busy8 && !pb) begin
        q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
        if (last >= 0) check("period8", 32'(cyc - last), 32'd10);
        last = cyc;
        n++;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      pb = busy8;
    end
    start8 = 1'b0;
    if (n < 1000) fail("b2b_timeout");

    // WIDTH=1 instance
    go1(1'b1, 1'b1, 1'b1, 2'b11);
    go1(1'b0, 1'b0, 1'b0, 2'b00);
    go1(1'b1, 1'b0, 1'b0, 2'b01);

    repeat (20) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
